// File: rtl/trace_player_pkg.sv
// Shared types and helpers for the event trace player.
// Optional feature macro: TRACE_LOOP_EN (see event_trace_player.sv).
package trace_player_pkg;

  // Default geometry of a trace; the top module parameters start from these.
  localparam int NUM_CH_DEF = 2;
  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 16;
  localparam int GAP_W_DEF  = 32;

  // Replay sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE,
    DONE
  } state_t;

  // One stored event at the default geometry: spacing, channel strobes, values.
  typedef struct packed {
    logic [GAP_W_DEF-1:0]             gap;
    logic [NUM_CH_DEF-1:0]            mask;
    logic [NUM_CH_DEF*DATA_W_DEF-1:0] data;
  } trace_entry_t;

  // Pointer width able to hold every value 0..depth (one extra bit for "full").
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_store.sv
// Single-port trace memory: synchronous write, combinational read at the
// same address. The sequencer only writes while idle, so the one address
// port is shared between loading and replay without conflict.
module trace_store
  import trace_player_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Entry write; NOTE: the array has no reset -- emptiness is tracked by the
  // write pointer, so clearing the storage itself would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/event_trace_player.sv
// Replays a stored trace of timestamped events into a monitor's
// input_k / new_input_k ports with cycle-exact spacing.
// Optional feature macro TRACE_LOOP_EN adds a 'loop' input that makes the
// last fire wrap back to entry 0 instead of finishing.
module event_trace_player
  import trace_player_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int GAP_W  = GAP_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef TRACE_LOOP_EN
  input  logic                       loop,
`endif
  input  logic                       en,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [GAP_W-1:0]           load_gap,
  input  logic [NUM_CH-1:0]          load_mask,
  input  logic [NUM_CH*DATA_W-1:0]   load_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       hold,
  output logic [NUM_CH*DATA_W-1:0]   input_data,
  output logic [NUM_CH-1:0]          new_input,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     fired_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0]    FULL = PW'(DEPTH);
  localparam logic [GAP_W-1:0] ONE  = GAP_W'(1);

  typedef struct packed {
    logic [GAP_W-1:0]         gap;
    logic [NUM_CH-1:0]        mask;
    logic [NUM_CH*DATA_W-1:0] data;
  } entry_t;

  entry_t                   wr_entry;
  entry_t                   rd_entry;
  logic [AW-1:0]            addr;
  logic                     we;

  state_t                   state_q, state_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            fired_q, fired_d;
  logic [PW-1:0]            rd_nxt;
  logic [GAP_W-1:0]         cnt_q, cnt_d;
  logic [GAP_W-1:0]         cur_gap;
  logic                     first_q, first_d;
  logic                     fire_d;
  logic                     last;
  logic                     wrap;
  logic [NUM_CH*DATA_W-1:0] fire_data;

  assign wr_entry = '{gap: load_gap, mask: load_mask, data: load_data};
  assign rd_nxt   = rd_ptr_q + PW'(1);
  assign last     = (rd_nxt == wr_ptr_q);

`ifdef TRACE_LOOP_EN
  assign wrap = last && loop;
`else
  assign wrap = 1'b0;
`endif

  trace_store #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_store (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wr_entry),
    .rdata (rd_entry)
  );

  // Masked-off channels present zero to the monitor.
  always_comb begin
    fire_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_entry.mask[k]) begin
        fire_data[k*DATA_W +: DATA_W] = rd_entry.data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic. WAIT reads the entry about to fire; FIRE reads the
  // following entry so a gap of 0/1 can go straight to another FIRE.
  // The first WAIT cycle after start takes its gap straight from the store
  // (first_q), which keeps the IDLE address port free for loading.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fired_d  = fired_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    fire_d   = 1'b0;
    we       = 1'b0;
    addr     = '0;
    cur_gap  = '0;

    case (state_q)
      IDLE: begin
        addr = wr_ptr_q[AW-1:0];
        if (clear) begin
          wr_ptr_d = '0;
        end else begin
          if (load_valid && load_ready) begin
            we       = en;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
          if (start && (wr_ptr_q != '0)) begin
            state_d  = WAIT;
            rd_ptr_d = '0;
            fired_d  = '0;
            first_d  = 1'b1;
          end
        end
      end

      WAIT: begin
        addr    = rd_ptr_q[AW-1:0];
        cur_gap = first_q ? rd_entry.gap : cnt_q;
        first_d = 1'b0;
        if ((cur_gap <= ONE) && !hold) begin
          state_d = FIRE;
          fire_d  = 1'b1;
        end else begin
          cnt_d = (cur_gap == '0) ? '0 : cur_gap - ONE;
        end
      end

      FIRE: begin
        addr    = last ? '0 : rd_nxt[AW-1:0];
        cur_gap = rd_entry.gap;
        fired_d = fired_q + PW'(1);
        if (last && !wrap) begin
          state_d  = DONE;
          rd_ptr_d = rd_nxt;
        end else begin
          rd_ptr_d = wrap ? '0 : rd_nxt;
          // The FIRE cycle itself counts toward the next gap.
          if ((cur_gap <= ONE) && !hold) begin
            state_d = FIRE;
            fire_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = (cur_gap == '0) ? '0 : cur_gap - ONE;
          end
        end
      end

      DONE: begin
        if (clear) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end else if (start) begin
          state_d  = WAIT;
          rd_ptr_d = '0;
          fired_d  = '0;
          first_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state register; en low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fired_q  <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fired_q  <= fired_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  // Registered outputs, computed from next-state values so nothing is combinational.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      new_input  <= '0;
      input_data <= '0;
    end else if (en) begin
      load_ready <= (state_d == IDLE) && (wr_ptr_d != FULL);
      busy       <= (state_d == WAIT) || (state_d == FIRE);
      done       <= (state_d == DONE);
      new_input  <= fire_d ? rd_entry.mask : '0;
      input_data <= fire_d ? fire_data : '0;
    end
  end

  assign fired_cnt = fired_q;

endmodule

// File: tb/tb_event_trace_player.sv
// Directed bench for event_trace_player at default geometry.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_event_trace_player;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int GAP_W  = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     loop;
  logic                     en;
  logic                     load_valid;
  logic                     load_ready;
  logic [GAP_W-1:0]         load_gap;
  logic [NUM_CH-1:0]        load_mask;
  logic [NUM_CH*DATA_W-1:0] load_data;
  logic                     clear;
  logic                     start;
  logic                     hold;
  logic [NUM_CH*DATA_W-1:0] input_data;
  logic [NUM_CH-1:0]        new_input;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH):0]   fired_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_trace_player #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP_W  (GAP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TRACE_LOOP_EN
    .loop       (loop),
`endif
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_gap   (load_gap),
    .load_mask  (load_mask),
    .load_data  (load_data),
    .clear      (clear),
    .start      (start),
    .hold       (hold),
    .input_data (input_data),
    .new_input  (new_input),
    .busy       (busy),
    .done       (done),
    .fired_cnt  (fired_cnt)
  );

  task automatic reset_dut;
    en = 1'b1; loop = 1'b0; load_valid = 1'b0; load_gap = '0; load_mask = '0;
    load_data = '0; clear = 1'b0; start = 1'b0; hold = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_one(input int gap, input logic [1:0] mask, input int d1, input int d0);
    load_valid = 1'b1;
    load_gap   = GAP_W'(gap);
    load_mask  = mask;
    load_data  = {64'(d1), 64'(d0)};
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic start_pulse;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles until the next strobe, bounded by max (returns max on timeout).
  task automatic wait_fire(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < max && new_input == '0);
  endtask

  task automatic test_reset;
    reset_dut();
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
    checks++;
    if ({busy, done, new_input, fired_cnt} !== '0) begin
      errors++; $display("FAIL reset_status got busy=%b done=%b new=%b cnt=%0d want all 0", busy, done, new_input, fired_cnt);
    end
    checks++;
    if (input_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", input_data); end
  endtask

  task automatic test_spec_replay;
    int n;
    reset_dut();
    for (int k = 1; k <= 5; k++) load_one(1000, 2'b11, k, k);
    start_pulse();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL replay_busy got %b want 1", busy); end
    for (int k = 1; k <= 5; k++) begin
      wait_fire(1100, n);
      checks++;
      if (n !== 1000) begin errors++; $display("FAIL replay_spacing_%0d got %0d want 1000", k, n); end
      checks++;
      if (input_data !== {64'(k), 64'(k)} || new_input !== 2'b11) begin
        errors++; $display("FAIL replay_data_%0d got %0h/%b want %0h/11", k, input_data, new_input, {64'(k), 64'(k)});
      end
      checks++;
      if (fired_cnt !== 5'(k - 1)) begin errors++; $display("FAIL replay_cnt_%0d got %0d want %0d", k, fired_cnt, k - 1); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || new_input !== '0 || fired_cnt !== 5'd5) begin
      errors++; $display("FAIL replay_done got done=%b busy=%b new=%b cnt=%0d want 1/0/00/5", done, busy, new_input, fired_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    reset_dut();
    load_one(0, 2'b01, 0, 7);
    load_one(1, 2'b01, 0, 8);
    load_one(1, 2'b01, 0, 9);
    start_pulse();
    wait_fire(10, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL b2b_first got %0d want 1", n); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (new_input !== 2'b01 || input_data !== {64'd0, 64'(7 + k)}) begin
        errors++; $display("FAIL b2b_fire_%0d got %b/%0h want 01/%0h", k, new_input, input_data, 7 + k);
      end
    end
    @(negedge clk);
    checks++;
    if (fired_cnt !== 5'd3 || done !== 1'b1 || new_input !== '0) begin
      errors++; $display("FAIL b2b_end got cnt=%0d done=%b new=%b want 3/1/00", fired_cnt, done, new_input);
    end
  endtask

  task automatic test_partial_mask;
    int n;
    reset_dut();
    load_one(3, 2'b10, 9, 4);
    start_pulse();
    wait_fire(10, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL mask_latency got %0d want 3", n); end
    checks++;
    if (new_input !== 2'b10 || input_data !== {64'd9, 64'd0}) begin
      errors++; $display("FAIL mask_fire got %b/%0h want 10/%0h", new_input, input_data, {64'd9, 64'd0});
    end
    // en low stretches the strobe.
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (new_input !== 2'b10 || done !== 1'b0) begin
      errors++; $display("FAIL en_stretch got new=%b done=%b want 10/0", new_input, done);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || new_input !== '0) begin
      errors++; $display("FAIL mask_done got done=%b new=%b want 1/00", done, new_input);
    end
  endtask

  task automatic test_hold;
    int f1 = -1;
    int f2 = -1;
    reset_dut();
    load_one(10, 2'b01, 0, 1);
    load_one(5, 2'b10, 2, 0);
    start_pulse();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 7) hold = 1'b1;
      if (c == 14) hold = 1'b0;
      if (new_input != '0) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
    end
    checks++;
    if (f1 !== 15) begin errors++; $display("FAIL hold_first got %0d want 15", f1); end
    checks++;
    if (f2 !== 20) begin errors++; $display("FAIL hold_second got %0d want 20", f2); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL hold_done got %b want 1", done); end
  endtask

  task automatic test_full_clear;
    int acc = 0;
    int fires = 0;
    logic [63:0] last_ch0 = '0;
    reset_dut();
    for (int i = 0; i <= DEPTH; i++) begin
      load_valid = 1'b1;
      load_gap   = 32'd1;
      load_mask  = 2'b01;
      load_data  = {64'd0, 64'(i)};
      if (load_ready) acc++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    checks++;
    if (acc !== DEPTH || load_ready !== 1'b0) begin
      errors++; $display("FAIL full_accept got %0d ready=%b want %0d ready=0", acc, load_ready, DEPTH);
    end
    start_pulse();
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (new_input != '0) begin fires++; last_ch0 = input_data[63:0]; end
    end
    checks++;
    if (fires !== DEPTH || done !== 1'b1 || fired_cnt !== 5'(DEPTH)) begin
      errors++; $display("FAIL full_replay got fires=%0d done=%b cnt=%0d want %0d/1/%0d", fires, done, fired_cnt, DEPTH, DEPTH);
    end
    checks++;
    if (last_ch0 !== 64'd15) begin errors++; $display("FAIL full_last_entry got %0d want 15", last_ch0); end
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL clear_beats_start got done=%b busy=%b ready=%b want 0/0/1", done, busy, load_ready);
    end
    start_pulse();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_after_clear got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_wait;
    int seen = 0;
    reset_dut();
    load_one(50, 2'b11, 3, 3);
    start_pulse();
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy got %b want 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({busy, done, new_input, fired_cnt} !== '0 || input_data !== '0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL midwait_reset got busy=%b done=%b new=%b cnt=%0d ready=%b want 0/0/00/0/1",
                         busy, done, new_input, fired_cnt, load_ready);
    end
    start_pulse();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy || new_input != '0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midwait_start_ignored got %0d active cycles want 0", seen); end
  endtask

`ifdef TRACE_LOOP_EN
  task automatic test_loop;
    int fires = 0;
    reset_dut();
    load_one(2, 2'b01, 0, 1);
    load_one(2, 2'b01, 0, 2);
    loop = 1'b1;
    start_pulse();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (new_input != '0) fires++;
    end
    checks++;
    if (fires !== 20 || done !== 1'b0) begin
      errors++; $display("FAIL loop_fires got %0d done=%b want 20/0", fires, done);
    end
    loop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_spec_replay();
    test_back_to_back();
    test_partial_mask();
    test_hold();
    test_full_clear();
    test_reset_mid_wait();
`ifdef TRACE_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
